// File: rtl/fetch_issue_queue.sv
// Instruction fetch and issue buffer: fetches LANES words per request from a
// one-cycle-latency memory and presents the oldest LANES entries in program order.
module fetch_issue_queue #(
    parameter int          IW       = 16,
    parameter int          PCW      = 8,
    parameter int          LANES    = 2,
    parameter int          DEPTH    = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [PCW-1:0]         flush_pc,
    output logic                   fetch_req,
    output logic [PCW-1:0]         fetch_pc,
    input  logic [LANES*IW-1:0]    fetch_data,
    output logic [LANES-1:0]       issue_valid,
    output logic [LANES*IW-1:0]    issue_ir,
    output logic [LANES*PCW-1:0]   issue_pc,
    input  logic [LANES-1:0]       issue_accept
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [IW-1:0]  ir_mem [DEPTH];
    logic [PCW-1:0] pc_mem [DEPTH];
    logic [AW-1:0]  head;
    logic [AW-1:0]  tail;
    logic [CW-1:0]  count;
    logic           pending;
    logic [PCW-1:0] req_pc;
    logic [CW-1:0]  pop_n;
    logic           run;
    logic           push;
    logic [31:0]    occ;

    // Occupancy if the in-flight fetch and a new one both land.
    assign occ       = 32'(count) + (pending ? 32'(LANES) : 32'd0) + 32'(LANES);
    assign fetch_req = !rst && !flush && (occ <= 32'(DEPTH));
    assign push      = pending && !flush;

    always_comb begin
        issue_valid = '0;
        issue_ir    = '0;
        issue_pc    = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            issue_valid[k]           = (k < 32'(count));
            issue_ir[k*IW +: IW]     = ir_mem[head + AW'(k)];
            issue_pc[k*PCW +: PCW]   = pc_mem[head + AW'(k)];
        end
    end

    // Only the contiguous accepted-and-valid run from lane 0 is popped.
    always_comb begin
        pop_n = '0;
        run   = 1'b1;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (run && issue_accept[k] && issue_valid[k]) begin
                pop_n = pop_n + CW'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                ir_mem[tail + AW'(k)] <= fetch_data[k*IW +: IW];
                pc_mem[tail + AW'(k)] <= req_pc + PCW'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            pending  <= 1'b0;
            req_pc   <= '0;
            fetch_pc <= PCW'(RESET_PC);
        end else if (flush) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            pending  <= 1'b0;
            fetch_pc <= flush_pc;
        end else begin
            head    <= head + AW'(pop_n);
            count   <= count + (push ? CW'(LANES) : CW'(0)) - pop_n;
            pending <= fetch_req;
            if (push) begin
                tail <= tail + AW'(LANES);
            end
            if (fetch_req) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + PCW'(LANES);
            end
        end
    end
endmodule

// File: tb/tb_fetch_issue_queue.sv
// Randomised scoreboard bench for fetch_issue_queue with a ROM-backed memory model.
module tb_fetch_issue_queue;
    localparam int IW    = 16;
    localparam int PCW   = 8;
    localparam int LANES = 2;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [IW-1:0]  ir;
        logic [PCW-1:0] pc;
    } ent_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 flush = 1'b0;
    logic [PCW-1:0]       flush_pc = '0;
    logic                 fetch_req;
    logic [PCW-1:0]       fetch_pc;
    logic [LANES*IW-1:0]  fetch_data = '0;
    logic [LANES-1:0]     issue_valid;
    logic [LANES*IW-1:0]  issue_ir;
    logic [LANES*PCW-1:0] issue_pc;
    logic [LANES-1:0]     issue_accept = '0;

    int errors = 0;
    int checks = 0;

    logic [IW-1:0] rom [256];
    ent_t          sb[$];
    logic          mpend = 1'b0;
    logic [PCW-1:0] mreq = '0;
    logic [PCW-1:0] mpc = '0;
    logic          known = 1'b0;
    logic          mem_pend = 1'b0;
    logic [PCW-1:0] mem_addr = '0;

    always #5 clk = ~clk;

    fetch_issue_queue #(
        .IW(IW), .PCW(PCW), .LANES(LANES), .DEPTH(DEPTH), .RESET_PC(0)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_data(fetch_data),
        .issue_valid(issue_valid), .issue_ir(issue_ir), .issue_pc(issue_pc),
        .issue_accept(issue_accept)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, then check and advance the reference model.
    task automatic step(input logic r, input logic f, input logic [PCW-1:0] fpc,
                        input logic [LANES-1:0] acc);
        logic exp_req;
        @(negedge clk);
        rst = r;
        flush = f;
        flush_pc = fpc;
        issue_accept = acc;
        for (int k = 0; k < LANES; k++)
            fetch_data[k*IW +: IW] = mem_pend ? rom[8'(mem_addr + k)] : IW'($urandom);
        #1;
        exp_req = !r && !f && (sb.size() + (mpend ? LANES : 0) + LANES <= DEPTH);
        if (known) begin
            check("fetch_req", 32'(fetch_req), 32'(exp_req));
            check("fetch_pc", 32'(fetch_pc), 32'(mpc));
            for (int k = 0; k < LANES; k++) begin
                check("issue_valid", 32'(issue_valid[k]), 32'(k < sb.size()));
                if (k < sb.size()) begin
                    check("lane_ir", 32'(issue_ir[k*IW +: IW]), 32'(sb[k].ir));
                    check("lane_pc", 32'(issue_pc[k*PCW +: PCW]), 32'(sb[k].pc));
                end
            end
        end
        mem_pend = fetch_req;
        mem_addr = fetch_pc;
        if (r) begin
            sb.delete();
            mpend = 1'b0;
            mpc = '0;
            known = 1'b1;
        end else if (f) begin
            sb.delete();
            mpend = 1'b0;
            mpc = fpc;
        end else begin
            if (mpend)
                for (int k = 0; k < LANES; k++)
                    sb.push_back('{ir: rom[8'(mreq + k)], pc: 8'(mreq + k)});
            mpend = exp_req;
            if (exp_req) begin
                mreq = mpc;
                mpc = mpc + 8'(LANES);
            end
        end
    endtask

    // Monitor: every lane actually consumed must match the scoreboard head.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && !flush) begin
                for (int k = 0; k < LANES; k++) begin
                    if (!(issue_valid[k] && issue_accept[k])) break;
                    if (sb.size() == 0) begin
                        check("pop_underflow", 32'(sb.size()), 32'd1);
                        break;
                    end
                    e = sb.pop_front();
                    check("issued_ir", 32'(issue_ir[k*IW +: IW]), 32'(e.ir));
                    check("issued_pc", 32'(issue_pc[k*PCW +: PCW]), 32'(e.pc));
                end
            end
        end
    end

    initial begin
        logic r, f;
        for (int i = 0; i < 256; i++) rom[i] = IW'($urandom);
        rom[0] = 16'hD002;
        rom[1] = 16'hD102;
        rom[2] = 16'hA168;
        rom[3] = 16'hA188;

        repeat (2) step(1'b1, 1'b0, 8'h00, 2'b00);
        repeat (6) step(1'b0, 1'b0, 8'h00, 2'b11);
        step(1'b0, 1'b1, 8'h00, 2'b11);
        repeat (10) step(1'b0, 1'b0, 8'h00, 2'b00);
        step(1'b0, 1'b0, 8'h00, 2'b01);
        step(1'b0, 1'b0, 8'h00, 2'b10);
        repeat (8) step(1'b0, 1'b0, 8'h00, 2'b11);
        step(1'b0, 1'b1, 8'h40, 2'b11);
        repeat (6) step(1'b0, 1'b0, 8'h00, 2'b11);
        step(1'b0, 1'b1, 8'hFF, 2'b00);
        repeat (3) step(1'b0, 1'b0, 8'h00, 2'b00);
        repeat (14) step(1'b0, 1'b0, 8'h00, 2'b11);

        for (int i = 0; i < 500; i++) begin
            r = ($urandom_range(0, 199) == 0);
            f = !r && ($urandom_range(0, 23) == 0);
            step(r, f, PCW'($urandom), LANES'($urandom));
        end
        repeat (12) step(1'b0, 1'b0, 8'h00, 2'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_issue_queue.md
# fetch_issue_queue

Parametrised instruction fetch and issue buffer for the multi-lane pipelined `cpu`. It replaces the per-pipe test-only instruction and PC inputs with a real front end. It fetches LANES instruction words per request from a synchronous instruction memory and queues them in program order. It presents the oldest LANES entries to execution lanes 0..LANES-1 and accepts partial issue, so the hazard logic can issue only lane 0. Flush/redirect is supported for branches.

## Interface
- `IW`, 16: instruction word width.
- `PCW`, 8: PC width; all PC arithmetic is mod 2^PCW.
- `LANES`, 2: issue lanes and words per fetch. Must be ≥1.
- `DEPTH`, 8: queue entries. Power of two, ≥ 2*LANES.
- `RESET_PC`, 0: first fetch address after reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  redirect: discard queue and in-flight fetch.
- `flush_pc`  in  PCW  new fetch address when `flush`=1.
- `fetch_req`  out  1  fetch request to instruction memory this cycle.
- `fetch_pc`  out  PCW  base address of the request. Word k is at fetch_pc+k.
- `fetch_data`  in  LANES*IW  memory return, exactly 1 cycle after the `fetch_req` cycle. Word k is at bits [k*IW +: IW].
- `issue_valid`  out  LANES  lane k holds a valid entry. Always thermometer from lane 0.
- `issue_ir`  out  LANES*IW  instruction per lane; lane 0 is the oldest.
- `issue_pc`  out  LANES*PCW  PC per lane.
- `issue_accept`  in  LANES  consumer takes lanes. Only the contiguous run of ones from lane 0 that is also valid counts.

## Operation
- State: circular storage of DEPTH entries, each {IR, PC}. `head`, `tail` (log2 DEPTH bits, wrapping), `count` (0..DEPTH), `pending` flag, `fetch_pc` register.
- Issue view: lane k shows entry head+k (mod DEPTH). `issue_valid[k]` = (k < count). Outputs are read combinationally from registers, with no extra latency.
- Pop: pop_n = length of the leading run of `issue_accept & issue_valid` starting at lane 0. Example: accept=0b10 gives pop_n=0. head += pop_n.
- Request: `fetch_req` = !rst && !flush && (count + pending*LANES + LANES ≤ DEPTH). When asserted, the next cycle has pending=1 and fetch_pc += LANES.
- Push: when pending=1 and flush=0, all LANES words of `fetch_data` are written at tail..tail+LANES-1 with PC = (requested base + k) mod 2^PCW, and tail += LANES.
- The count update combines the push and the pop: count_next = count + push*LANES − pop_n. The request condition guarantees a push never overflows. Pops never exceed count.
- Flush (priority over push/pop/request):
  - head = tail = count = 0; pending = 0; fetch_pc = flush_pc.
  - Data returning in the flush cycle is discarded.
  - `issue_accept` is ignored in the flush cycle.
- Reset (priority over all): count=0, head=tail=0, pending=0, fetch_pc=RESET_PC. A reset mid-fetch discards the return.

## Timing
- Reset values: fetch_req=0, fetch_pc=RESET_PC, issue_valid=0. issue_ir and issue_pc are don't-care while invalid.
- Fetch-to-issue latency:
  - Request in cycle t; data sampled at the end of cycle t+1.
  - Entries are visible on the issue outputs in cycle t+2.
- Steady state with full acceptance: one request and LANES issued per cycle. There are no bubbles after the first 2 cycles.
- Redirect latency: flush in cycle t; fetch_req=1 with fetch_pc=flush_pc in t+1; first valid issue in t+3.
- The memory must tolerate back-to-back requests. `fetch_data` is ignored in any cycle where pending=0.

## Test plan
- Reset: hold rst 2 cycles → fetch_req=0, issue_valid=0, fetch_pc=0x00. In the first cycle after release, fetch_req=1 and fetch_pc=0x00. fetch_pc=0x02 in the next cycle.
- Streaming: ROM[0]=0xD002 (MOV R0,#2), ROM[1]=0xD102 (MOV R1,#2), ROM[2]=0xA168, ROM[3]=0xA188, accept=0b11.
  - 2 cycles after the first request: lane0={0xD002,0x00}, lane1={0xD102,0x01}.
  - Next cycle: {0xA168,0x02} and {0xA188,0x03}.
- Backpressure: accept=0b00 held → count reaches 8 and fetch_req stays 0. The outputs hold 0xD002/0xD102 unchanged. Release to 0b11 → drains in program order with no loss or duplication.
- Partial issue:
  - accept=0b01 once → lane0 becomes {0xD102,0x01}, lane1 becomes {0xA168,0x02}.
  - accept=0b10 → no pop.
- Flush while a fetch is pending (flush_pc=0x40) → next cycle issue_valid=0 and the in-flight data is dropped. fetch_req=1 with pc 0x40; first valid issue pc=0x40 in flush cycle+3.
- Wrap: flush_pc=0xFF → lane0 pc=0xFF, lane1 pc=0x00, following fetch_pc=0x01. Run >DEPTH pushes to confirm head/tail wrap.
